// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared definitions for the VGA raster timing generator:
//   - default 640x480@60 timing constants (pixel clock 25.175 MHz class)
//   - calc_total(): line/frame length from active + porches + sync
//   - in_window():  half-open window compare used for sync decode
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic int calc_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // True when start <= cnt < start + width.
    function automatic logic in_window(input int cnt, input int start,
                                       input int width);
        return (cnt >= start) && (cnt < start + width);
    endfunction

endpackage

// File: rtl/vga_raster_cnt.sv
// ---------------------------------------------------------------------------
// vga_raster_cnt
// Horizontal/vertical counter pair for one raster position. The pair resets
// to (H_START, V_START) and advances by one pixel on every i_ce; h wraps at
// H_TOTAL-1 and carries into v, which wraps at V_TOTAL-1.
// The position the pair moves to on the next tick is exported, so the parent
// can register its decode in the same cycle the counters update.
// Ports:
//   clk       in   clock
//   rst       in   synchronous reset, active-high
//   i_ce      in   pixel tick enable
//   o_h_nxt   out  h after the next tick
//   o_v_nxt   out  v after the next tick
// ---------------------------------------------------------------------------
module vga_raster_cnt
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL = calc_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP),
    parameter int V_TOTAL = calc_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP),
    parameter int H_START = 0,
    parameter int V_START = 0,
    parameter int HW      = $clog2(H_TOTAL),
    parameter int VW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_ce,
    output logic [HW-1:0] o_h_nxt,
    output logic [VW-1:0] o_v_nxt
);

    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic          w_h_last;
    logic          w_v_last;

    always_comb begin
        w_h_last = (r_h == HW'(H_TOTAL - 1));
        w_v_last = (r_v == VW'(V_TOTAL - 1));
        o_h_nxt  = w_h_last ? '0 : r_h + HW'(1);
        o_v_nxt  = r_v;
        if (w_h_last) begin
            o_v_nxt = w_v_last ? '0 : r_v + VW'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (rst) begin
            r_h <= HW'(H_START);
            r_v <= VW'(V_START);
        end else if (i_ce) begin
            r_h <= o_h_nxt;
            r_v <= o_v_nxt;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA raster timing generator. A display counter pair drives
// sync, blanking and coordinates; a second pair runs LEAD pixel ticks ahead
// and produces the prefetch coordinate stream for screen/char RAM lookups.
// All outputs are registered and move only on pix_ce (or rst).
// Ports:
//   clk            in   clock
//   rst            in   synchronous reset, active-high (priority over pix_ce)
//   pix_ce         in   pixel tick enable
//   h_sync_o       out  horizontal sync, active level HS_POL
//   v_sync_o       out  vertical sync, active level VS_POL
//   active_o       out  current pixel is visible
//   posx / posy    out  display coordinate, 0 while blanked
//   line_start_o   out  one-clk pulse on the tick where h becomes 0
//   frame_start_o  out  one-clk pulse on the tick where h and v become 0
//   fetch_valid_o  out  fetch coordinate is visible
//   fetch_x/y      out  coordinate to fetch now, displayed LEAD ticks later
// ---------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int LEAD     = 2,
    parameter int XW       = 10,
    parameter int YW       = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_ce,
    output logic          h_sync_o,
    output logic          v_sync_o,
    output logic          active_o,
    output logic [XW-1:0] posx,
    output logic [YW-1:0] posy,
    output logic          line_start_o,
    output logic          frame_start_o,
    output logic          fetch_valid_o,
    output logic [XW-1:0] fetch_x,
    output logic [YW-1:0] fetch_y
);

    localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    if (H_ACTIVE < 1 || H_SYNC < 1 || V_ACTIVE < 1 || V_SYNC < 1 ||
        H_FP < 0 || H_BP < 0 || V_FP < 0 || V_BP < 0) begin : g_bad_timing
        $error("vga_timing_gen: active and sync widths must be >= 1, porches >= 0");
    end
    if (LEAD < 0 || LEAD >= H_TOTAL) begin : g_bad_lead
        $error("vga_timing_gen: LEAD must lie in 0..H_TOTAL-1");
    end
    if (H_ACTIVE > 2**XW || V_ACTIVE > 2**YW) begin : g_bad_width
        $error("vga_timing_gen: XW/YW too narrow for the visible window");
    end

    typedef struct packed {
        logic          h_sync;
        logic          v_sync;
        logic          active;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          fetch_valid;
        logic [XW-1:0] fx;
        logic [YW-1:0] fy;
    } out_t;

    logic [HW-1:0] w_h_nxt;
    logic [VW-1:0] w_v_nxt;
    logic [HW-1:0] w_fh_nxt;
    logic [VW-1:0] w_fv_nxt;

    int   w_dh, w_dv, w_fh, w_fv;
    out_t w_out;
    logic w_line_start;
    logic w_frame_start;

    out_t r_out;
    logic r_line_start;
    logic r_frame_start;

    vga_raster_cnt #(
        .H_TOTAL (H_TOTAL), .V_TOTAL (V_TOTAL),
        .H_START (0),       .V_START (0),
        .HW      (HW),      .VW      (VW)
    ) u_disp_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_ce    (pix_ce),
        .o_h_nxt (w_h_nxt),
        .o_v_nxt (w_v_nxt)
    );

    // LEAD < H_TOTAL, so the fetch pair starts on line 0 without a carry.
    vga_raster_cnt #(
        .H_TOTAL (H_TOTAL), .V_TOTAL (V_TOTAL),
        .H_START (LEAD),    .V_START (0),
        .HW      (HW),      .VW      (VW)
    ) u_fetch_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_ce    (pix_ce),
        .o_h_nxt (w_fh_nxt),
        .o_v_nxt (w_fv_nxt)
    );

    // Decode the position the counters are about to hold; under reset that is
    // the reset position, so one decode path serves both load cases.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves a value unassigned and infers a latch.
        w_out = '0;
        w_dh  = rst ? 0    : int'(w_h_nxt);
        w_dv  = rst ? 0    : int'(w_v_nxt);
        w_fh  = rst ? LEAD : int'(w_fh_nxt);
        w_fv  = rst ? 0    : int'(w_fv_nxt);

        w_out.active = (w_dh < H_ACTIVE) && (w_dv < V_ACTIVE);
        if (w_out.active) begin
            w_out.x = XW'(w_dh);
            w_out.y = YW'(w_dv);
        end
        w_out.h_sync = in_window(w_dh, H_ACTIVE + H_FP, H_SYNC) ? HS_POL : ~HS_POL;
        w_out.v_sync = in_window(w_dv, V_ACTIVE + V_FP, V_SYNC) ? VS_POL : ~VS_POL;

        w_out.fetch_valid = (w_fh < H_ACTIVE) && (w_fv < V_ACTIVE);
        if (w_out.fetch_valid) begin
            w_out.fx = XW'(w_fh);
            w_out.fy = YW'(w_fv);
        end

        w_line_start  = (w_dh == 0);
        w_frame_start = (w_dh == 0) && (w_dv == 0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out         <= w_out;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (pix_ce) begin
            r_out         <= w_out;
            r_line_start  <= w_line_start;
            r_frame_start <= w_frame_start;
        end else begin
            // Strobes last one clk even if pix_ce stays low afterwards.
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

    assign h_sync_o      = r_out.h_sync;
    assign v_sync_o      = r_out.v_sync;
    assign active_o      = r_out.active;
    assign posx          = r_out.x;
    assign posy          = r_out.y;
    assign fetch_valid_o = r_out.fetch_valid;
    assign fetch_x       = r_out.fx;
    assign fetch_y       = r_out.fy;
    assign line_start_o  = r_line_start;
    assign frame_start_o = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Four generator instances share clk/rst/pix_ce:
//   0: default 640x480 timing, LEAD=2
//   1: tiny raster H 4/1/1/1, V 3/1/1/1, LEAD=2
//   2: 20/3/5/4 x 10/2/3/2, both syncs active-high, LEAD=0
//   3: same raster as 2, active-low syncs, LEAD=H_TOTAL-1
// The reference model tracks only the number of pixel ticks since reset and
// derives every output from it by division/modulo.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int N = 4;
    localparam int HA [N] = '{640, 4, 20, 20};
    localparam int HF [N] = '{16,  1, 3,  3};
    localparam int HSW[N] = '{96,  1, 5,  5};
    localparam int HB [N] = '{48,  1, 4,  4};
    localparam int VA [N] = '{480, 3, 10, 10};
    localparam int VF [N] = '{10,  1, 2,  2};
    localparam int VSW[N] = '{2,   1, 3,  3};
    localparam int VB [N] = '{33,  1, 2,  2};
    localparam int LD [N] = '{2,   2, 0,  31};
    localparam bit HP [N] = '{1'b0, 1'b0, 1'b1, 1'b0};
    localparam bit VP [N] = '{1'b0, 1'b0, 1'b1, 1'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic ce  = 1'b0;

    logic [N-1:0] hs_w, vs_w, act_w, ls_w, fs_w, fv_w;
    logic [9:0]   px_w [N];
    logic [9:0]   py_w [N];
    logic [9:0]   fx_w [N];
    logic [9:0]   fy_w [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        vga_timing_gen #(
            .H_ACTIVE (HA[g]), .H_FP (HF[g]), .H_SYNC (HSW[g]), .H_BP (HB[g]),
            .V_ACTIVE (VA[g]), .V_FP (VF[g]), .V_SYNC (VSW[g]), .V_BP (VB[g]),
            .HS_POL   (HP[g]), .VS_POL (VP[g]), .LEAD (LD[g]),
            .XW       (10),    .YW (10)
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .pix_ce        (ce),
            .h_sync_o      (hs_w[g]),
            .v_sync_o      (vs_w[g]),
            .active_o      (act_w[g]),
            .posx          (px_w[g]),
            .posy          (py_w[g]),
            .line_start_o  (ls_w[g]),
            .frame_start_o (fs_w[g]),
            .fetch_valid_o (fv_w[g]),
            .fetch_x       (fx_w[g]),
            .fetch_y       (fy_w[g])
        );
    end

    typedef struct {
        logic hs;
        logic vs;
        logic act;
        int   px;
        int   py;
        logic fv;
        int   fx;
        int   fy;
    } exp_t;

    int     total = 0;
    int     bad   = 0;
    longint t     = 0;       // pixel ticks since the last reset
    logic   armed = 1'b0;
    logic [N-1:0] exp_ls = '0;
    logic [N-1:0] exp_fs = '0;

    task automatic check(input string nm, input int g,
                         input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s[%0d] got=%0d want=%0d tick=%0d", nm, g, got, want, t);
        end
    endtask

    function automatic int htot(input int g);
        return HA[g] + HF[g] + HSW[g] + HB[g];
    endfunction

    function automatic int vtot(input int g);
        return VA[g] + VF[g] + VSW[g] + VB[g];
    endfunction

    // Outputs after tt ticks: position is tt modulo the frame, split into
    // line and pixel; the fetch position is simply LEAD ticks further on.
    function automatic exp_t predict(input int g, input longint tt);
        exp_t   e;
        longint fr, p, q;
        int     h, v, fh, fv;
        fr = longint'(htot(g)) * longint'(vtot(g));
        p  = tt % fr;
        q  = (tt + longint'(LD[g])) % fr;
        h  = int'(p % longint'(htot(g)));
        v  = int'(p / longint'(htot(g)));
        fh = int'(q % longint'(htot(g)));
        fv = int'(q / longint'(htot(g)));
        e.act = (h < HA[g]) && (v < VA[g]);
        e.px  = e.act ? h : 0;
        e.py  = e.act ? v : 0;
        e.hs  = (h >= HA[g] + HF[g] && h < HA[g] + HF[g] + HSW[g]) ? HP[g] : !HP[g];
        e.vs  = (v >= VA[g] + VF[g] && v < VA[g] + VF[g] + VSW[g]) ? VP[g] : !VP[g];
        e.fv  = (fh < HA[g]) && (fv < VA[g]);
        e.fx  = e.fv ? fh : 0;
        e.fy  = e.fv ? fv : 0;
        return e;
    endfunction

    // Model: advance the tick count exactly where the DUT samples rst/pix_ce.
    always @(posedge clk) begin : model
        longint nt;
        nt = rst ? 0 : (ce ? t + 1 : t);
        for (int g = 0; g < N; g++) begin
            longint fr;
            fr = longint'(htot(g)) * longint'(vtot(g));
            exp_ls[g] <= !rst && ce && ((nt % longint'(htot(g))) == 0);
            exp_fs[g] <= !rst && ce && ((nt % fr) == 0);
        end
        t <= nt;
        if (rst) armed <= 1'b1;
    end

    // Compare on the falling edge, away from the sampling edge.
    always @(negedge clk) begin : compare
        exp_t e;
        if (armed) begin
            for (int g = 0; g < N; g++) begin
                e = predict(g, t);
                check("h_sync",      g, 32'(hs_w[g]),   32'(e.hs));
                check("v_sync",      g, 32'(vs_w[g]),   32'(e.vs));
                check("active",      g, 32'(act_w[g]),  32'(e.act));
                check("posx",        g, 32'(px_w[g]),   e.px);
                check("posy",        g, 32'(py_w[g]),   e.py);
                check("line_start",  g, 32'(ls_w[g]),   32'(exp_ls[g]));
                check("frame_start", g, 32'(fs_w[g]),   32'(exp_fs[g]));
                check("fetch_valid", g, 32'(fv_w[g]),   32'(e.fv));
                check("fetch_x",     g, 32'(fx_w[g]),   e.fx);
                check("fetch_y",     g, 32'(fy_w[g]),   e.fy);
            end
        end
    end

    initial begin
        int first_low, low_cnt, ls1, ls2;
        first_low = -1;
        low_cnt   = 0;
        ls1       = -1;
        ls2       = -1;

        // Reset state, hand-computed.
        rst = 1'b1;
        ce  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_posx",      0, 32'(px_w[0]),  0);
        check("rst_posy",      0, 32'(py_w[0]),  0);
        check("rst_active",    0, 32'(act_w[0]), 1);
        check("rst_hsync",     0, 32'(hs_w[0]),  1);
        check("rst_vsync",     0, 32'(vs_w[0]),  1);
        check("rst_fetch_x",   0, 32'(fx_w[0]),  2);
        check("rst_line_st",   0, 32'(ls_w[0]),  0);
        check("rst_hsync_pos", 2, 32'(hs_w[2]),  0);
        check("rst_fetch_x",   3, 32'(fx_w[3]),  0);
        check("rst_fetch_vld", 3, 32'(fv_w[3]),  0);

        // Continuous ticks: default-mode line timing and tiny-raster fetch lead.
        rst = 1'b0;
        ce  = 1'b1;
        for (int k = 1; k <= 1700; k++) begin
            @(negedge clk);
            if (k < 800 && hs_w[0] == 1'b0) begin
                low_cnt++;
                if (first_low < 0) first_low = k;
            end
            if (ls_w[0]) begin
                if (ls1 < 0) ls1 = k;
                else if (ls2 < 0) ls2 = k;
            end
            if (k == 1) check("b_fetch_x_t1",   1, 32'(fx_w[1]), 3);
            if (k == 2) begin
                check("b_fetch_vld_t2", 1, 32'(fv_w[1]),  0);
                check("b_active_t2",    1, 32'(act_w[1]), 1);
            end
            if (k == 4) check("b_active_t4",    1, 32'(act_w[1]), 0);
            if (k == 5) check("b_fetch_y_t5",   1, 32'(fy_w[1]), 1);
            if (k == 41) check("b_frame_st_41", 1, 32'(fs_w[1]), 0);
            if (k == 42) check("b_frame_st_42", 1, 32'(fs_w[1]), 1);
        end
        check("hsync_start",  0, first_low, 656);
        check("hsync_width",  0, low_cnt,   96);
        check("first_line",   0, ls1,       800);
        check("line_period",  0, ls2 - ls1, 800);

        // pix_ce pattern 1,0,0,1.
        for (int r = 0; r < 60; r++) begin
            ce = 1'b1; @(negedge clk);
            ce = 1'b0; @(negedge clk);
            ce = 1'b0; @(negedge clk);
            ce = 1'b1; @(negedge clk);
        end

        // Random pixel enables with occasional single-cycle resets.
        for (int k = 0; k < 15000; k++) begin
            ce  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 1999) == 0);
            @(negedge clk);
        end

        // Mid-frame reset at h=300, v=2 of the default raster.
        rst = 1'b1;
        ce  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ce  = 1'b1;
        repeat (1900) @(negedge clk);
        check("pre_rst_posx", 0, 32'(px_w[0]), 300);
        check("pre_rst_posy", 0, 32'(py_w[0]), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_posx",   0, 32'(px_w[0]),  0);
        check("mid_rst_posy",   0, 32'(py_w[0]),  0);
        check("mid_rst_active", 0, 32'(act_w[0]), 1);
        check("mid_rst_hsync",  0, 32'(hs_w[0]),  1);
        check("mid_rst_vsync",  0, 32'(vs_w[0]),  1);
        check("mid_rst_fetchx", 0, 32'(fx_w[0]),  2);
        repeat (900) @(negedge clk);
        check("resume_posx", 0, 32'(px_w[0]), 100);
        check("resume_posy", 0, 32'(py_w[0]), 1);
        ce = 1'b0;
        repeat (5) @(negedge clk);
        check("frozen_posx", 0, 32'(px_w[0]), 100);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
